conv_fold_addr_gen: RTL and testbench

Parametrised address and control generator for the folded convolution datapath. It sweeps a K×K kernel window across an IMG_H×IMG_W feature map with configurable stride, emitting one feature-map/weight address pair per cycle to the single shared MAC. It replaces the fixed 7×7 / 5×5 / two-kernel controller with start/done handshaking, stall support, selectable kernel banks, and pipeline-aligned accumulate and output strobes.

---
 rtl/conv_fold_pkg.sv | 38 +++
 rtl/fold_win_counter.sv | 82 ++++++++
 rtl/conv_fold_addr_gen.sv | 216 +++++++++++++++++++++
 tb/tb_conv_fold_addr_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_fold_pkg.sv
// Shared types, default geometry and helper functions for the folded
// convolution address generator.
package conv_fold_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } fold_state_e;

  localparam int unsigned DEF_IMG_W    = 7;
  localparam int unsigned DEF_IMG_H    = 7;
  localparam int unsigned DEF_K        = 5;
  localparam int unsigned DEF_STRIDE   = 1;
  localparam int unsigned DEF_NUM_KER  = 2;
  localparam int unsigned DEF_FA_W     = 6;
  localparam int unsigned DEF_WA_W     = 6;
  localparam int unsigned DEF_PIPE_LAT = 2;

  // Output-map width; trailing columns that do not fit a full window are dropped.
  function automatic int unsigned out_w(input int unsigned img_w,
                                        input int unsigned k,
                                        input int unsigned stride);
    return (img_w - k) / stride + 1;
  endfunction

  function automatic int unsigned out_h(input int unsigned img_h,
                                        input int unsigned k,
                                        input int unsigned stride);
    return (img_h - k) / stride + 1;
  endfunction

  // Counter/select width with a floor of one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fold_win_counter.sv
// Nested sweep counter: kc (innermost), kr, oc, or (outermost), with wrap
// flags describing the tap currently held in the counters.
module fold_win_counter
  import conv_fold_pkg::*;
#(
  parameter int unsigned K  = DEF_K,
  parameter int unsigned OW = 3,
  parameter int unsigned OH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic kc_wrap_o,
  output logic kr_wrap_o,
  output logic oc_wrap_o,
  output logic tap_first_o,
  output logic last_o
);

  localparam int unsigned KW  = cnt_w(K);
  localparam int unsigned OWW = cnt_w(OW);
  localparam int unsigned OHW = cnt_w(OH);

  logic [KW-1:0]  kc_q, kc_d;
  logic [KW-1:0]  kr_q, kr_d;
  logic [OWW-1:0] oc_q, oc_d;
  logic [OHW-1:0] or_q, or_d;
  logic           or_wrap;

  assign kc_wrap_o   = (kc_q == KW'(K - 1));
  assign kr_wrap_o   = (kr_q == KW'(K - 1));
  assign oc_wrap_o   = (oc_q == OWW'(OW - 1));
  assign or_wrap     = (or_q == OHW'(OH - 1));
  assign tap_first_o = (kc_q == '0) && (kr_q == '0);
  assign last_o      = kc_wrap_o && kr_wrap_o && oc_wrap_o && or_wrap;

  always_comb begin
    kc_d = kc_q;
    kr_d = kr_q;
    oc_d = oc_q;
    or_d = or_q;
    if (clr_i) begin
      kc_d = '0;
      kr_d = '0;
      oc_d = '0;
      or_d = '0;
    end else if (en_i) begin
      if (!kc_wrap_o) begin
        kc_d = kc_q + KW'(1);
      end else begin
        kc_d = '0;
        if (!kr_wrap_o) begin
          kr_d = kr_q + KW'(1);
        end else begin
          kr_d = '0;
          if (!oc_wrap_o) begin
            oc_d = oc_q + OWW'(1);
          end else begin
            oc_d = '0;
            or_d = or_wrap ? '0 : or_q + OHW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_q <= '0;
      kr_q <= '0;
      oc_q <= '0;
      or_q <= '0;
    end else begin
      kc_q <= kc_d;
      kr_q <= kr_d;
      oc_q <= oc_d;
      or_q <= or_d;
    end
  end

endmodule

// File: rtl/conv_fold_addr_gen.sv
// Address/control generator sweeping a KxK window over the feature map,
// one fmap/weight address pair per cycle, with aligned MAC strobes.
module conv_fold_addr_gen
  import conv_fold_pkg::*;
#(
  parameter int unsigned IMG_W    = DEF_IMG_W,
  parameter int unsigned IMG_H    = DEF_IMG_H,
  parameter int unsigned K        = DEF_K,
  parameter int unsigned STRIDE   = DEF_STRIDE,
  parameter int unsigned NUM_KER  = DEF_NUM_KER,
  parameter int unsigned FA_W     = DEF_FA_W,
  parameter int unsigned WA_W     = DEF_WA_W,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [cnt_w(NUM_KER)-1:0]   ker_sel,
  input  logic                        hold,
  output logic                        busy,
  output logic                        done,
  output logic                        cs,
  output logic                        we,
  output logic [FA_W-1:0]             addr_fmaps,
  output logic [WA_W-1:0]             addr_weight,
  output logic                        worken,
  output logic                        acc_clr,
  output logic                        outputen
);

  localparam int unsigned OW   = out_w(IMG_W, K, STRIDE);
  localparam int unsigned OH   = out_h(IMG_H, K, STRIDE);
  localparam int unsigned KS_W = cnt_w(NUM_KER);

  localparam logic [FA_W-1:0] ROW_STEP  = FA_W'(IMG_W);
  localparam logic [FA_W-1:0] COL_STEP  = FA_W'(STRIDE);
  localparam logic [FA_W-1:0] LINE_STEP = FA_W'(STRIDE * IMG_W);
  localparam logic [WA_W-1:0] WROW_STEP = WA_W'(K);

  fold_state_e state_q, state_d;

  logic [FA_W-1:0] line_q, line_d;
  logic [FA_W-1:0] win_q, win_d;
  logic [FA_W-1:0] row_q, row_d;
  logic [FA_W-1:0] addr_f_q, addr_f_d;
  logic [WA_W-1:0] wt_base_q, wt_base_d;
  logic [WA_W-1:0] wrow_q, wrow_d;
  logic [WA_W-1:0] addr_w_q, addr_w_d;
  logic            cs_q, cs_d;
  logic            done_q, done_d;

  logic [PIPE_LAT-1:0] dl_cs_q, dl_cs_d;
  logic [PIPE_LAT-1:0] dl_first_q, dl_first_d;
  logic [PIPE_LAT-1:0] dl_last_q, dl_last_d;

  logic            cnt_clr, cnt_en;
  logic            kc_wrap, kr_wrap, oc_wrap, tap_first, last_tap;
  logic [WA_W-1:0] ker_base;
  logic [FA_W-1:0] win_nxt, line_nxt;

  fold_win_counter #(
    .K  (K),
    .OW (OW),
    .OH (OH)
  ) u_win_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .kc_wrap_o   (kc_wrap),
    .kr_wrap_o   (kr_wrap),
    .oc_wrap_o   (oc_wrap),
    .tap_first_o (tap_first),
    .last_o      (last_tap)
  );

  // Kernel base selected from a constant table rather than ker_sel*K*K.
  always_comb begin
    ker_base = '0;
    for (int unsigned i = 0; i < NUM_KER; i++) begin
      if (ker_sel == KS_W'(i)) ker_base = WA_W'(i * K * K);
    end
  end

  assign win_nxt  = win_q + COL_STEP;
  assign line_nxt = line_q + LINE_STEP;

  // Delay line is fed from the registered cs so strobes track hold bubbles.
  always_comb begin
    dl_cs_d       = dl_cs_q;
    dl_first_d    = dl_first_q;
    dl_last_d     = dl_last_q;
    dl_cs_d[0]    = cs_q;
    dl_first_d[0] = cs_q && tap_first;
    dl_last_d[0]  = cs_q && kc_wrap && kr_wrap;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      dl_cs_d[i]    = dl_cs_q[i-1];
      dl_first_d[i] = dl_first_q[i-1];
      dl_last_d[i]  = dl_last_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    win_d     = win_q;
    row_d     = row_q;
    addr_f_d  = addr_f_q;
    wt_base_d = wt_base_q;
    wrow_d    = wrow_q;
    addr_w_d  = addr_w_q;
    cs_d      = 1'b0;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // done_q blocks a restart in the very cycle done is reported.
        if (start && !done_q) begin
          state_d   = ST_RUN;
          cnt_clr   = 1'b1;
          line_d    = '0;
          win_d     = '0;
          row_d     = '0;
          addr_f_d  = '0;
          wt_base_d = ker_base;
          wrow_d    = ker_base;
          addr_w_d  = ker_base;
          cs_d      = 1'b1;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          if (last_tap) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_en = 1'b1;
            cs_d   = 1'b1;
            if (!kc_wrap) begin
              addr_f_d = addr_f_q + FA_W'(1);
              addr_w_d = addr_w_q + WA_W'(1);
            end else if (!kr_wrap) begin
              row_d    = row_q + ROW_STEP;
              addr_f_d = row_q + ROW_STEP;
              wrow_d   = wrow_q + WROW_STEP;
              addr_w_d = wrow_q + WROW_STEP;
            end else begin
              wrow_d   = wt_base_q;
              addr_w_d = wt_base_q;
              if (!oc_wrap) begin
                win_d    = win_nxt;
                row_d    = win_nxt;
                addr_f_d = win_nxt;
              end else begin
                line_d   = line_nxt;
                win_d    = line_nxt;
                row_d    = line_nxt;
                addr_f_d = line_nxt;
              end
            end
          end
        end
      end
      ST_DRAIN: begin
        if (dl_cs_d == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      win_q      <= '0;
      row_q      <= '0;
      addr_f_q   <= '0;
      wt_base_q  <= '0;
      wrow_q     <= '0;
      addr_w_q   <= '0;
      cs_q       <= 1'b0;
      done_q     <= 1'b0;
      dl_cs_q    <= '0;
      dl_first_q <= '0;
      dl_last_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      win_q      <= win_d;
      row_q      <= row_d;
      addr_f_q   <= addr_f_d;
      wt_base_q  <= wt_base_d;
      wrow_q     <= wrow_d;
      addr_w_q   <= addr_w_d;
      cs_q       <= cs_d;
      done_q     <= done_d;
      dl_cs_q    <= dl_cs_d;
      dl_first_q <= dl_first_d;
      dl_last_q  <= dl_last_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign cs          = cs_q;
  assign we          = 1'b0;
  assign addr_fmaps  = addr_f_q;
  assign addr_weight = addr_w_q;
  assign worken      = dl_cs_q[PIPE_LAT-1];
  assign acc_clr     = dl_first_q[PIPE_LAT-1];
  assign outputen    = dl_last_q[PIPE_LAT-1];

endmodule

// File: tb/tb_conv_fold_addr_gen.sv
// Directed bench for conv_fold_addr_gen: default geometry instance plus a
// strided 8x8/K=3 instance, with hand-derived expected addresses and timing.
module tb_conv_fold_addr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start_a = 1'b0, hold_a = 1'b0;
  logic [0:0] ker_a = '0;
  logic       busy_a, done_a, cs_a, we_a, worken_a, acc_clr_a, outputen_a;
  logic [5:0] fa_a, wa_a;

  logic       start_b = 1'b0, hold_b = 1'b0;
  logic [0:0] ker_b = '0;
  logic       busy_b, done_b, cs_b, we_b, worken_b, acc_clr_b, outputen_b;
  logic [5:0] fa_b, wa_b;

  int n_vec = 0;
  int n_err = 0;

  int fmap_seq [256];
  int wt_seq   [256];
  int oe_cyc   [16];
  int n_oe;
  int done_cyc;

  always #5 clk = ~clk;

  conv_fold_addr_gen u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_a),
    .ker_sel     (ker_a),
    .hold        (hold_a),
    .busy        (busy_a),
    .done        (done_a),
    .cs          (cs_a),
    .we          (we_a),
    .addr_fmaps  (fa_a),
    .addr_weight (wa_a),
    .worken      (worken_a),
    .acc_clr     (acc_clr_a),
    .outputen    (outputen_a)
  );

  conv_fold_addr_gen #(
    .IMG_W    (8),
    .IMG_H    (8),
    .K        (3),
    .STRIDE   (2),
    .NUM_KER  (2),
    .FA_W     (6),
    .WA_W     (6),
    .PIPE_LAT (3)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .ker_sel     (ker_b),
    .hold        (hold_b),
    .busy        (busy_b),
    .done        (done_b),
    .cs          (cs_b),
    .we          (we_b),
    .addr_fmaps  (fa_b),
    .addr_weight (wa_b),
    .worken      (worken_b),
    .acc_clr     (acc_clr_b),
    .outputen    (outputen_b)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one pass in the current cycle and follows it to done.
  task automatic run_pass(input string tag, input bit inst, input int ker,
                          input int W, input int K, input int S,
                          input int OW, input int OH, input int PL,
                          input int hold_at, input int hold_len, input int restart_at);
    int total;
    int n_taps, addr_err, align_err, busy_err, bubbles;
    int kc, kr, oc, orr, e_fa, e_wa;
    bit cs_h [601];
    bit fst_h[601];
    bit lst_h[601];
    bit s_cs, s_busy, s_done, s_we, s_wk, s_clr, s_oe;
    bit e_wk, e_clr, e_oe;
    int s_fa, s_wa;
    total     = OW * OH * K * K;
    n_taps    = 0;
    addr_err  = 0;
    align_err = 0;
    busy_err  = 0;
    bubbles   = 0;
    n_oe      = 0;
    done_cyc  = -1;
    if (inst) begin start_b = 1'b1; ker_b = 1'(ker); end
    else      begin start_a = 1'b1; ker_a = 1'(ker); end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (inst) begin
        s_cs = cs_b; s_busy = busy_b; s_done = done_b; s_we = we_b;
        s_wk = worken_b; s_clr = acc_clr_b; s_oe = outputen_b;
        s_fa = int'(fa_b); s_wa = int'(wa_b);
      end else begin
        s_cs = cs_a; s_busy = busy_a; s_done = done_a; s_we = we_a;
        s_wk = worken_a; s_clr = acc_clr_a; s_oe = outputen_a;
        s_fa = int'(fa_a); s_wa = int'(wa_a);
      end
      if (s_cs) begin
        if (n_taps < total) begin
          kc   = n_taps % K;
          kr   = (n_taps / K) % K;
          oc   = (n_taps / (K * K)) % OW;
          orr  = n_taps / (K * K * OW);
          e_fa = (orr * S + kr) * W + oc * S + kc;
          e_wa = ker * K * K + kr * K + kc;
          if (s_fa != e_fa || s_wa != e_wa) addr_err++;
          fmap_seq[n_taps] = s_fa;
          wt_seq[n_taps]   = s_wa;
          fst_h[c] = (n_taps % (K * K) == 0);
          lst_h[c] = (n_taps % (K * K) == K * K - 1);
        end else begin
          addr_err++;
        end
        n_taps++;
      end else if (n_taps < total) begin
        bubbles++;
      end
      cs_h[c] = s_cs;
      e_wk  = (c > PL) ? cs_h[c-PL]  : 1'b0;
      e_clr = (c > PL) ? fst_h[c-PL] : 1'b0;
      e_oe  = (c > PL) ? lst_h[c-PL] : 1'b0;
      if (s_wk != e_wk || s_clr != e_clr || s_oe != e_oe) align_err++;
      if (s_oe) begin
        if (n_oe < 16) oe_cyc[n_oe] = c;
        n_oe++;
      end
      if (s_we) busy_err++;
      if (s_done) begin
        done_cyc = c;
        if (s_busy) busy_err++;
        break;
      end
      if (!s_busy) busy_err++;
      if (inst) hold_b = (c >= hold_at) && (c < hold_at + hold_len);
      else      hold_a = (c >= hold_at) && (c < hold_at + hold_len);
      if (c == restart_at) begin
        if (inst) begin start_b = 1'b1; ker_b = ~ker_b; end
        else      begin start_a = 1'b1; ker_a = ~ker_a; end
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      tick();
    end
    hold_a  = 1'b0;
    hold_b  = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    check({tag, ".taps"},      n_taps, total);
    check({tag, ".addr_errs"}, addr_err, 0);
    check({tag, ".align_errs"}, align_err, 0);
    check({tag, ".busy_errs"}, busy_err, 0);
    check({tag, ".bubbles"},   bubbles, hold_len);
    check({tag, ".n_outputen"}, n_oe, OW * OH);
    check({tag, ".done_cycle"}, done_cyc, total + PL + 1 + hold_len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    check("reset.outs_a", {busy_a, done_a, cs_a, we_a, worken_a, acc_clr_a, outputen_a, fa_a, wa_a}, 0);
    check("reset.outs_b", {busy_b, done_b, cs_b, we_b, worken_b, acc_clr_b, outputen_b, fa_b, wa_b}, 0);
    rst_n = 1'b1;
    tick();

    run_pass("t1", 1'b0, 0, 7, 5, 1, 3, 3, 2, 0, 0, 0);
    check("t1.fa4",   fmap_seq[4], 4);
    check("t1.fa5",   fmap_seq[5], 7);
    check("t1.fa9",   fmap_seq[9], 11);
    check("t1.fa25",  fmap_seq[25], 1);
    check("t1.fa224", fmap_seq[224], 48);
    check("t1.wa224", wt_seq[224], 24);
    check("t1.oe0",   oe_cyc[0], 27);
    check("t1.oe_gap", oe_cyc[1] - oe_cyc[0], 25);
    tick();

    run_pass("t2", 1'b0, 1, 7, 5, 1, 3, 3, 2, 0, 0, 0);
    check("t2.wa0",   wt_seq[0], 25);
    check("t2.wa24",  wt_seq[24], 49);
    check("t2.wa25",  wt_seq[25], 25);
    check("t2.fa25",  fmap_seq[25], 1);
    check("t2.fa224", fmap_seq[224], 48);
    tick();

    run_pass("t3", 1'b1, 0, 8, 3, 2, 3, 3, 3, 0, 0, 0);
    check("t3.fa9",  fmap_seq[9], 2);
    check("t3.fa27", fmap_seq[27], 16);
    check("t3.oe0",  oe_cyc[0], 12);
    tick();

    run_pass("t4", 1'b0, 0, 7, 5, 1, 3, 3, 2, 12, 4, 0);
    check("t4.fa12", fmap_seq[12], 16);
    check("t4.fa13", fmap_seq[13], 17);
    check("t4.oe0",  oe_cyc[0], 31);
    tick();

    run_pass("t5", 1'b0, 0, 7, 5, 1, 3, 3, 2, 0, 0, 50);
    start_a = 1'b1;
    ker_a   = '0;
    tick();
    start_a = 1'b0;
    check("t5.done_start_busy", busy_a, 0);
    check("t5.done_start_cs",   cs_a, 0);
    run_pass("t6", 1'b0, 0, 7, 5, 1, 3, 3, 2, 0, 0, 0);
    check("t6.fa0", fmap_seq[0], 0);
    tick();

    start_a = 1'b1;
    ker_a   = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid.outs_a", {busy_a, done_a, cs_a, we_a, worken_a, acc_clr_a, outputen_a, fa_a, wa_a}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_pass("t7", 1'b0, 0, 7, 5, 1, 3, 3, 2, 0, 0, 0);
    check("t7.fa0", fmap_seq[0], 0);
    check("t7.wa0", wt_seq[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
